// File: rtl/pool_max_thermo.sv
// Streaming max-pool over WINDOW 4-bit samples, emitting each window maximum
// as a registered 15-bit thermometer code through a one-entry output slot.
module pool_max_thermo #(
   parameter int WINDOW = 4,
   parameter int CW     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  pixel,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] thermo,
   output logic        out_partial
);

   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   logic [3:0]    r_max;
   logic [CW-1:0] r_cnt;
   logic          r_out_valid;
   logic [14:0]   r_thermo;
   logic          r_partial;

   logic          w_accept;
   logic          w_flush;
   logic          w_last;
   logic [3:0]    w_new_max;
   logic          w_close_acc;
   logic          w_close_idle;
   logic          w_close;
   logic [3:0]    w_close_max;
   logic          w_close_partial;

   function automatic logic [14:0] encode(input logic [3:0] m);
      return 15'h7FFF >> (4'd15 - m);
   endfunction

   // The only combinational output path: out_ready frees the slot this cycle.
   assign in_ready = !r_out_valid || out_ready;

   assign w_accept  = in_valid && in_ready;
   assign w_flush   = flush && in_ready;
   assign w_last    = (r_cnt == LAST);
   assign w_new_max = (r_cnt == '0) ? pixel : ((pixel > r_max) ? pixel : r_max);

   assign w_close_acc     = w_accept && (w_last || w_flush);
   assign w_close_idle    = !w_accept && w_flush && (r_cnt != '0);
   assign w_close         = w_close_acc || w_close_idle;
   assign w_close_max     = w_accept ? w_new_max : r_max;
   // A flush landing on the last sample is still a full window.
   assign w_close_partial = w_accept ? !w_last : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_thermo    <= '0;
         r_partial   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_max <= w_new_max;
            r_cnt <= w_close_acc ? '0 : r_cnt + CW'(1);
         end else if (w_close_idle) begin
            r_cnt <= '0;
         end

         if (w_close) begin
            r_thermo    <= encode(w_close_max);
            r_partial   <= w_close_partial;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign thermo      = r_thermo;
   assign out_partial = r_partial;

endmodule

// File: tb/tb_pool_max_thermo.sv
// Self-checking bench for pool_max_thermo: directed scenarios plus a random
// run compared against a sample-queue reference model.
module tb_pool_max_thermo;

   localparam int WINDOW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  pixel;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] thermo;
   logic        out_partial;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int          win[$];
   logic        exp_ov;
   logic [14:0] exp_th;
   logic        exp_part;
   logic        exp_rdy;
   logic        obs_rdy;

   pool_max_thermo #(.WINDOW(WINDOW), .CW(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pixel(pixel), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .thermo(thermo), .out_partial(out_partial)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      win.delete();
      exp_ov   = 1'b0;
      exp_th   = '0;
      exp_part = 1'b0;
   endtask

   // One clock of stimulus; model advances by the rules of the block.
   task automatic drive(input logic v, input logic [3:0] p, input logic f, input logic r);
      logic acc, fl, close;
      int   m;
      @(negedge clk);
      in_valid = v; pixel = p; flush = f; out_ready = r;
      #1;
      obs_rdy = in_ready;
      exp_rdy = !exp_ov || r;
      acc = v && exp_rdy;
      fl  = f && exp_rdy;
      if (acc) win.push_back(int'(p));
      close = (acc && (win.size() == WINDOW || fl)) || (!acc && fl && win.size() > 0);
      if (close) begin
         m = 0;
         foreach (win[i]) if (win[i] > m) m = win[i];
         exp_th   = 15'((1 << m) - 1);
         exp_part = (win.size() < WINDOW);
         exp_ov   = 1'b1;
         win.delete();
      end else if (exp_ov && r) begin
         exp_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; pixel = '0;
      model_clear();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || thermo !== 15'h0 || out_partial !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset: ov=%b th=%h part=%b rdy=%b want 0 0000 0 1", out_valid, thermo, out_partial, in_ready);
      end
      release_reset();
   endtask

   task automatic test_basic();
      logic [3:0] px[4] = '{4'd3, 4'd9, 4'd2, 4'd7};
      for (int i = 0; i < 4; i++) begin
         drive(1, px[i], 0, 1);
         n_checks++;
         if (out_valid !== (i == 3)) begin
            n_errors++;
            $display("FAIL basic_ov[%0d]: got %b want %b", i, out_valid, (i == 3));
         end
      end
      n_checks++;
      if (thermo !== 15'h01FF || out_partial !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_thermo: got %h/%b want 01ff/0", thermo, out_partial);
      end
      drive(0, 0, 0, 1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_consume: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drive(1, (i < 4) ? 4'd0 : 4'd15, 0, 1);
         if (i == 3 || i == 7) begin
            n_checks++;
            if (out_valid !== 1'b1 || thermo !== ((i == 3) ? 15'h0000 : 15'h7FFF) || out_partial !== 1'b0) begin
               n_errors++;
               $display("FAIL b2b_win%0d: ov=%b th=%h part=%b", i / 4, out_valid, thermo, out_partial);
            end
         end
         n_checks++;
         if (obs_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_rdy[%0d]: got %b want 1", i, obs_rdy);
         end
      end
      drive(0, 0, 0, 1);
   endtask

   task automatic test_backpressure();
      logic [3:0] px[4] = '{4'd4, 4'd1, 4'd1, 4'd1};
      for (int i = 0; i < 4; i++) drive(1, px[i], 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'd15, 1, 0);
         n_checks++;
         if (obs_rdy !== 1'b0 || out_valid !== 1'b1 || thermo !== 15'h000F || out_partial !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: rdy=%b ov=%b th=%h part=%b want 0 1 000f 0", i, obs_rdy, out_valid, thermo, out_partial);
         end
      end
      drive(0, 0, 0, 1);
      n_checks++;
      if (obs_rdy !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_release: rdy=%b ov=%b want 1 0", obs_rdy, out_valid);
      end
   endtask

   task automatic test_flush();
      drive(1, 4'd5, 0, 1);
      drive(1, 4'd1, 0, 1);
      drive(0, 4'd9, 1, 1);
      n_checks++;
      if (out_valid !== 1'b1 || thermo !== 15'h001F || out_partial !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_alone: ov=%b th=%h part=%b want 1 001f 1", out_valid, thermo, out_partial);
      end
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 1);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_empty: ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_simultaneous();
      // Full window closed by a flush on the last sample is not partial.
      for (int i = 0; i < 4; i++) drive(1, 4'(i + 6), (i == 3), 1);
      n_checks++;
      if (out_valid !== 1'b1 || thermo !== 15'h01FF || out_partial !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_last: ov=%b th=%h part=%b want 1 01ff 0", out_valid, thermo, out_partial);
      end
      // Single-sample flushed window replaces the held one while it is consumed.
      drive(1, 4'd2, 1, 1);
      n_checks++;
      if (out_valid !== 1'b1 || thermo !== 15'h0003 || out_partial !== 1'b1) begin
         n_errors++;
         $display("FAIL replace_a: ov=%b th=%h part=%b want 1 0003 1", out_valid, thermo, out_partial);
      end
      drive(1, 4'd6, 1, 1);
      n_checks++;
      if (out_valid !== 1'b1 || thermo !== 15'h003F || out_partial !== 1'b1) begin
         n_errors++;
         $display("FAIL replace_b: ov=%b th=%h part=%b want 1 003f 1", out_valid, thermo, out_partial);
      end
      drive(0, 0, 0, 1);
   endtask

   task automatic test_reset_mid();
      drive(1, 4'd14, 0, 1);
      drive(1, 4'd14, 0, 1);
      do_reset();
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_hold: ov=%b rdy=%b want 0 1", out_valid, in_ready);
         end
      end
      release_reset();
      for (int i = 0; i < 4; i++) drive(1, 4'd1, 0, 1);
      n_checks++;
      if (out_valid !== 1'b1 || thermo !== 15'h0001 || out_partial !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_win: ov=%b th=%h part=%b want 1 0001 0", out_valid, thermo, out_partial);
      end
      drive(0, 0, 0, 1);
   endtask

   task automatic test_random();
      logic v, f, r;
      logic [3:0] p;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 9) < 8);
         f = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 3) != 0);
         p = 4'($urandom_range(0, 15));
         drive(v, p, f, r);
         n_checks++;
         if (obs_rdy !== exp_rdy || out_valid !== exp_ov ||
             (exp_ov && (thermo !== exp_th || out_partial !== exp_part))) begin
            n_errors++;
            $display("FAIL random[%0d]: rdy=%b ov=%b th=%h part=%b want %b %b %h %b",
                     i, obs_rdy, out_valid, thermo, out_partial, exp_rdy, exp_ov, exp_th, exp_part);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; pixel = '0; flush = 1'b0; out_ready = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pool_max_thermo.md
# pool_max_thermo

Streaming max-pooling stage that feeds the thermometer-to-one-hot decoder in the pooling filter. It accepts 4-bit pixel samples over a valid/ready handshake and tracks the running maximum over a window of WINDOW samples. It emits each window's maximum as a registered 15-bit thermometer code. A flush input closes a partial window early.

## Interface
- WINDOW, default 4: samples per pooling window; legal range 2..16.
- CW, default 4: width of internal sample counter; must satisfy 2^CW >= WINDOW.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pixel is valid this cycle.
- in_ready  output  1  block accepts a pixel this cycle; combinational: !out_valid || out_ready.
- pixel  input  4  unsigned sample, 0..15.
- flush  input  1  close the current partial window; sampled only when in_ready=1.
- out_valid  output  1  thermo holds an unconsumed result.
- out_ready  input  1  downstream consumes the result.
- thermo  output  15  thermometer code of window max: thermo[i]=1 iff max > i (max=0 → all zeros, max=15 → all ones).
- out_partial  output  1  result came from a flushed window with fewer than WINDOW samples.

## Operation
- Accept: in_valid && in_ready.
- Registers: max_reg[3:0], cnt[CW-1:0], a one-entry output slot (thermo, out_partial, out_valid).
- Two implicit states: ACCUM (out_valid=0) and HOLD (out_valid=1). A slot being freed by out_ready in the same cycle counts as free.
- On accept with cnt=0: max_reg ← pixel. With cnt>0: max_reg ← max(max_reg, pixel). Unsigned compare.
- On accept with cnt=WINDOW-1 (window closes):
  - thermo ← encode(max(max_reg, pixel)); out_partial ← 0; out_valid ← 1; cnt ← 0.
- Otherwise, on accept: cnt ← cnt+1.
- Flush with in_ready=1:
  - With an accept in the same cycle: the sample is included, then the window closes. out_partial ← 1 unless cnt was already WINDOW-1, which is a normal close with out_partial=0.
  - Without an accept and cnt>0: close with the current max_reg; out_partial ← 1; cnt ← 0.
  - Without an accept and cnt=0: ignored, no output.
- Flush with in_ready=0: ignored; it is not remembered.
- Output handshake: out_valid && out_ready clears out_valid, unless a new window closes in the same cycle. In that case out_valid stays 1 and thermo/out_partial load the new result.
- While out_valid=1 and out_ready=0: thermo and out_partial are held stable and in_ready=0.
- Encoder: thermo = (15'h7FFF >> (15 - max)). Pure function of the 4-bit max, registered.

## Timing
- Reset (async assert, sync release): out_valid=0, thermo=15'h0000, out_partial=0, cnt=0, max_reg=0. in_ready=1 immediately.
- Latency: a closing sample accepted at edge N gives out_valid=1 with the final thermo from edge N until handshake.
- Throughput: with out_ready held 1, one result per WINDOW accepted samples, no bubbles.
- Reset mid-window discards the partial window and any held result. The first accept after release starts a fresh window.
- No combinational path from pixel or in_valid to any output. The only combinational path is out_ready → in_ready.

## Test plan
- WINDOW=4, out_ready=1, pixels 3,9,2,7 back-to-back → one out_valid pulse, thermo=15'h01FF, out_partial=0.
- Windows 0,0,0,0 then 15,15,15,15 → thermo=15'h0000, then thermo=15'h7FFF. Both appear on consecutive-window boundaries with no stall.
- Backpressure: window 4,1,1,1 completes with out_ready=0 for 3 cycles → thermo=15'h000F stable, in_ready=0. On out_ready=1, handshake occurs and in_ready returns to 1 the same cycle.
- Flush: accept 5,1, then flush alone → thermo=15'h001F, out_partial=1. A later flush with cnt=0 produces nothing.
- Simultaneous events:
  - out_ready=1 during the cycle the next window's 4th sample is accepted → out_valid stays 1 and thermo switches to the new value.
  - Flush plus accept at cnt=3 → out_partial=0.
- Reset mid-window: accept 14,14, assert rst, release, then accept 1,1,1,1 → thermo=15'h0001. out_valid=0 throughout reset.
